levenshtein: RTL and testbench

- Hardware engine that computes the Levenshtein (edit) distance between two byte strings held in shared memory.
- The host loads string pointers, lengths and a stack pointer through input ports, then raises the start/run level.
- The engine walks the strings over a simple single-master memory bus, using a scratch row below the stack pointer.
- It raises idle when finished, with the distance held on output a0.

---
 rtl/levenshtein.sv | 340 ++++++++++++++++++++++++++++++++++
 tb/tb_levenshtein.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/levenshtein.sv
// levenshtein: edit-distance engine over a single-master memory bus.
//
// The host presents string pointers, lengths and a stack pointer while setb=0.
// Raising setb starts a run. The engine keeps a single DP row of (lenA+1) words
// in scratch memory just below the stack pointer. It raises idle when the
// distance is on a0, and holds idle until setb drops.
//
// Ports:
//   clk, rstb          clock; synchronous active-high reset
//   setb               run level (0 = load/hold, 1 = run)
//   idle               result valid / engine done
//   pc0, ra0, s00, a40 captured only
//   sp0                stack pointer; scratch row lives below it
//   a00/a10            string A address / length (bytes)
//   a20/a30            string B address / length (bytes)
//   a0                 distance result
//   addr/size/write    access descriptor, held until ready
//   wdata              lane-positioned write data
//   valid              one-cycle request strobe
//   rdata/ready        aligned read word / access-complete pulse
//
// State      | meaning
// -----------+-------------------------------------------------------------
// S_LOAD     | latch host inputs every cycle; wait for setb
// S_INIT     | compute scratch row base, clear column counter
// S_IW_REQ   | issue write row[i] = i
// S_IW_WAIT  | wait for init write; step i up to lenA
// S_B_REQ    | issue byte read B[j-1]
// S_B_WAIT   | capture B byte; diag = j-1 (old row[0])
// S_R0_REQ   | issue write row[0] = j
// S_R0_WAIT  | wait for row[0] write; start inner loop
// S_A_REQ    | issue byte read A[i-1]
// S_A_WAIT   | capture A byte
// S_RR_REQ   | issue word read row[i]
// S_RR_WAIT  | compute new cell from old row[i], left, diag
// S_RW_REQ   | issue write row[i] = new
// S_RW_WAIT  | wait for cell write; advance i / j or finish
// S_DONE     | idle=1 with result on a0; back to S_LOAD when setb=0
module levenshtein (
  input  logic        clk,
  input  logic        rstb,
  input  logic        setb,
  output logic        idle,
  input  logic [7:0]  pc0,
  input  logic [31:0] ra0,
  input  logic [31:0] sp0,
  input  logic [31:0] s00,
  input  logic [31:0] a00,
  input  logic [31:0] a10,
  input  logic [31:0] a20,
  input  logic [31:0] a30,
  input  logic [31:0] a40,
  output logic [31:0] a0,
  output logic [31:0] addr,
  output logic [2:0]  size,
  output logic        valid,
  output logic        write,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        ready
);

  typedef enum logic [3:0] {
    S_LOAD, S_INIT, S_IW_REQ, S_IW_WAIT, S_B_REQ, S_B_WAIT, S_R0_REQ, S_R0_WAIT,
    S_A_REQ, S_A_WAIT, S_RR_REQ, S_RR_WAIT, S_RW_REQ, S_RW_WAIT, S_DONE
  } state_t;

  localparam logic [2:0] SZ_BYTE = 3'd0;
  localparam logic [2:0] SZ_WORD = 3'd2;

  state_t state_q, state_n;

  logic [31:0] stra_q, stra_n, lena_q, lena_n, strb_q, strb_n, lenb_q, lenb_n;
  logic [31:0] sp_q, sp_n, ra_q, ra_n, s0_q, s0_n, a4_q, a4_n;
  logic [7:0]  pc_q, pc_n;
  logic [31:0] base_q, base_n, i_q, i_n, j_q, j_n;
  logic [31:0] diag_q, diag_n, left_q, left_n;
  logic [7:0]  achar_q, achar_n, bchar_q, bchar_n;
  logic [31:0] a0_q, a0_n, addr_q, addr_n, wdata_q, wdata_n;
  logic [2:0]  size_q, size_n;
  logic        valid_q, valid_n, write_q, write_n;

  logic [7:0]  rbyte;
  logic [31:0] cost, up1, left1, diag_c, cell_new, acc_addr;
  logic        unused_capture;

  // Sub-word writes land on their byte lane; word writes are aligned so the
  // shift is zero for every scratch access.
  function automatic logic [31:0] lane(input logic [31:0] v, input logic [31:0] a);
    return v << {a[1:0], 3'b000};
  endfunction

  // addr_q is held for the whole access, so it still selects the lane when
  // ready arrives.
  assign rbyte  = 8'(rdata >> {addr_q[1:0], 3'b000});
  assign cost   = (achar_q != bchar_q) ? 32'd1 : 32'd0;
  assign up1    = rdata + 32'd1;
  assign left1  = left_q + 32'd1;
  assign diag_c = diag_q + cost;

  always_comb begin
    cell_new = up1;
    if (left1 < cell_new) cell_new = left1;
    if (diag_c < cell_new) cell_new = diag_c;
  end

  assign unused_capture = ^{pc_q, ra_q, s0_q, a4_q};

  assign a0    = a0_q;
  assign addr  = addr_q;
  assign size  = size_q;
  assign valid = valid_q;
  assign write = write_q;
  assign wdata = wdata_q;

  always_ff @(posedge clk) begin
    if (rstb) state_q <= S_LOAD;
    else      state_q <= state_n;
  end

  always_comb begin
    state_n  = state_q;
    idle     = 1'b0;
    stra_n   = stra_q;
    lena_n   = lena_q;
    strb_n   = strb_q;
    lenb_n   = lenb_q;
    sp_n     = sp_q;
    ra_n     = ra_q;
    s0_n     = s0_q;
    a4_n     = a4_q;
    pc_n     = pc_q;
    base_n   = base_q;
    i_n      = i_q;
    j_n      = j_q;
    diag_n   = diag_q;
    left_n   = left_q;
    achar_n  = achar_q;
    bchar_n  = bchar_q;
    a0_n     = a0_q;
    addr_n   = addr_q;
    size_n   = size_q;
    write_n  = write_q;
    wdata_n  = wdata_q;
    valid_n  = 1'b0;
    acc_addr = 32'd0;

    case (state_q)
      S_LOAD: begin
        stra_n = a00;
        lena_n = a10;
        strb_n = a20;
        lenb_n = a30;
        sp_n   = sp0;
        ra_n   = ra0;
        s0_n   = s00;
        a4_n   = a40;
        pc_n   = pc0;
        if (setb) state_n = S_INIT;
      end
      S_INIT: begin
        base_n  = sp_q - ((lena_q + 32'd1) << 2);
        i_n     = 32'd0;
        state_n = S_IW_REQ;
      end
      S_IW_REQ: begin
        acc_addr = base_q + {i_q[29:0], 2'b00};
        addr_n   = acc_addr;
        size_n   = SZ_WORD;
        write_n  = 1'b1;
        wdata_n  = lane(i_q, acc_addr);
        valid_n  = 1'b1;
        state_n  = S_IW_WAIT;
      end
      S_IW_WAIT: begin
        if (ready) begin
          if (i_q == lena_q) begin
            j_n = 32'd1;
            if (lenb_q == 32'd0) begin
              a0_n    = lena_q;
              state_n = S_DONE;
            end else begin
              state_n = S_B_REQ;
            end
          end else begin
            i_n     = i_q + 32'd1;
            state_n = S_IW_REQ;
          end
        end
      end
      S_B_REQ: begin
        addr_n  = strb_q + j_q - 32'd1;
        size_n  = SZ_BYTE;
        write_n = 1'b0;
        wdata_n = 32'd0;
        valid_n = 1'b1;
        state_n = S_B_WAIT;
      end
      S_B_WAIT: begin
        if (ready) begin
          bchar_n = rbyte;
          // row[0] always holds j-1 at this point, so no read is needed.
          diag_n  = j_q - 32'd1;
          state_n = S_R0_REQ;
        end
      end
      S_R0_REQ: begin
        addr_n  = base_q;
        size_n  = SZ_WORD;
        write_n = 1'b1;
        wdata_n = lane(j_q, base_q);
        valid_n = 1'b1;
        state_n = S_R0_WAIT;
      end
      S_R0_WAIT: begin
        if (ready) begin
          left_n = j_q;
          i_n    = 32'd1;
          if (lena_q != 32'd0) begin
            state_n = S_A_REQ;
          end else if (j_q == lenb_q) begin
            a0_n    = lenb_q;
            state_n = S_DONE;
          end else begin
            j_n     = j_q + 32'd1;
            state_n = S_B_REQ;
          end
        end
      end
      S_A_REQ: begin
        addr_n  = stra_q + i_q - 32'd1;
        size_n  = SZ_BYTE;
        write_n = 1'b0;
        wdata_n = 32'd0;
        valid_n = 1'b1;
        state_n = S_A_WAIT;
      end
      S_A_WAIT: begin
        if (ready) begin
          achar_n = rbyte;
          state_n = S_RR_REQ;
        end
      end
      S_RR_REQ: begin
        addr_n  = base_q + {i_q[29:0], 2'b00};
        size_n  = SZ_WORD;
        write_n = 1'b0;
        wdata_n = 32'd0;
        valid_n = 1'b1;
        state_n = S_RR_WAIT;
      end
      S_RR_WAIT: begin
        if (ready) begin
          diag_n  = rdata;
          left_n  = cell_new;
          state_n = S_RW_REQ;
        end
      end
      S_RW_REQ: begin
        acc_addr = base_q + {i_q[29:0], 2'b00};
        addr_n   = acc_addr;
        size_n   = SZ_WORD;
        write_n  = 1'b1;
        wdata_n  = lane(left_q, acc_addr);
        valid_n  = 1'b1;
        state_n  = S_RW_WAIT;
      end
      S_RW_WAIT: begin
        if (ready) begin
          if (i_q != lena_q) begin
            i_n     = i_q + 32'd1;
            state_n = S_A_REQ;
          end else if (j_q == lenb_q) begin
            a0_n    = left_q;
            state_n = S_DONE;
          end else begin
            j_n     = j_q + 32'd1;
            state_n = S_B_REQ;
          end
        end
      end
      S_DONE: begin
        idle = 1'b1;
        if (!setb) state_n = S_LOAD;
      end
      default: state_n = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstb) begin
      stra_q  <= '0;
      lena_q  <= '0;
      strb_q  <= '0;
      lenb_q  <= '0;
      sp_q    <= '0;
      ra_q    <= '0;
      s0_q    <= '0;
      a4_q    <= '0;
      pc_q    <= '0;
      base_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      diag_q  <= '0;
      left_q  <= '0;
      achar_q <= '0;
      bchar_q <= '0;
      a0_q    <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      valid_q <= 1'b0;
    end else begin
      stra_q  <= stra_n;
      lena_q  <= lena_n;
      strb_q  <= strb_n;
      lenb_q  <= lenb_n;
      sp_q    <= sp_n;
      ra_q    <= ra_n;
      s0_q    <= s0_n;
      a4_q    <= a4_n;
      pc_q    <= pc_n;
      base_q  <= base_n;
      i_q     <= i_n;
      j_q     <= j_n;
      diag_q  <= diag_n;
      left_q  <= left_n;
      achar_q <= achar_n;
      bchar_q <= bchar_n;
      a0_q    <= a0_n;
      addr_q  <= addr_n;
      size_q  <= size_n;
      write_q <= write_n;
      wdata_q <= wdata_n;
      valid_q <= valid_n;
    end
  end

endmodule

// File: tb/tb_levenshtein.sv
// Bench for levenshtein: byte memory with delayed ready, protocol monitor and
// a queue of expected distances popped when the engine goes idle.
module tb_levenshtein;
  logic        clk = 1'b0;
  logic        rstb, setb, idle, valid, write;
  logic        ready = 1'b0;
  logic [7:0]  pc0;
  logic [31:0] ra0, sp0, s00, a00, a10, a20, a30, a40;
  logic [31:0] a0, addr, wdata;
  logic [31:0] rdata = 32'd0;
  logic [2:0]  size;

  always #5 clk = ~clk;

  levenshtein dut (
    .clk(clk), .rstb(rstb), .setb(setb), .idle(idle), .pc0(pc0), .ra0(ra0),
    .sp0(sp0), .s00(s00), .a00(a00), .a10(a10), .a20(a20), .a30(a30), .a40(a40),
    .a0(a0), .addr(addr), .size(size), .valid(valid), .write(write),
    .wdata(wdata), .rdata(rdata), .ready(ready)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int exp_q[$];

  logic [7:0]  mem [0:16383];
  int          delay = 1;
  int          viol  = 0;
  int          cnt   = 0;
  bit          pend  = 0;
  bit          stray = 0;
  logic        valid_d = 1'b0;
  logic [31:0] p_addr, p_wdata, wlo, whi;
  logic [2:0]  p_size;
  logic        p_write;

  // Memory responder and protocol monitor, all on the falling edge.
  always @(negedge clk) begin
    int base;
    ready = 1'b0;
    if (rstb) begin
      if (pend) stray = 1;
      pend    = 0;
      valid_d = 1'b0;
    end else begin
      if (valid && valid_d) viol++;
      valid_d = valid;
      if (stray && !pend && !valid) begin
        ready = 1'b1;
        stray = 0;
      end else if (pend) begin
        if (addr !== p_addr || size !== p_size || write !== p_write) viol++;
        if (write && wdata !== p_wdata) viol++;
        if (valid) viol++;
        cnt--;
        if (cnt == 0) begin
          pend  = 0;
          ready = 1'b1;
          base  = int'({p_addr[13:2], 2'b00});
          if (p_write) begin
            if (p_addr < wlo || p_addr + 32'd4 > whi || p_size != 3'd2 || p_addr[1:0] != 2'b00)
              viol++;
            for (int b = 0; b < 4; b++) mem[base + b] = p_wdata[8*b +: 8];
          end else begin
            rdata = {mem[base + 3], mem[base + 2], mem[base + 1], mem[base]};
          end
        end
      end else if (valid) begin
        pend    = 1;
        cnt     = delay;
        p_addr  = addr;
        p_size  = size;
        p_write = write;
        p_wdata = wdata;
      end
    end
  end

  task automatic load_str(input logic [31:0] at, input string s);
    for (int k = 0; k < s.len(); k++) mem[int'(at[13:0]) + k] = s[k];
  endtask

  task automatic rand_str(input logic [31:0] at, input int len);
    for (int k = 0; k < len; k++) mem[int'(at[13:0]) + k] = 8'h61 + 8'($urandom_range(0, 3));
  endtask

  function automatic int lev_model(input logic [31:0] pa, input int la, input logic [31:0] pb,
                                   input int lb);
    int prev[], cur[];
    prev = new[la + 1];
    cur  = new[la + 1];
    for (int i = 0; i <= la; i++) prev[i] = i;
    for (int j = 1; j <= lb; j++) begin
      cur[0] = j;
      for (int i = 1; i <= la; i++) begin
        int c, m;
        c = (mem[int'(pa[13:0]) + i - 1] == mem[int'(pb[13:0]) + j - 1]) ? 0 : 1;
        m = prev[i] + 1;
        if (cur[i-1] + 1 < m) m = cur[i-1] + 1;
        if (prev[i-1] + c < m) m = prev[i-1] + c;
        cur[i] = m;
      end
      prev = cur;
    end
    return prev[la];
  endfunction

  task automatic start_run(input logic [31:0] pa, input int la, input logic [31:0] pb,
                           input int lb, input logic [31:0] sp, input int expd);
    @(negedge clk);
    setb = 1'b0;
    a00 = pa; a10 = la; a20 = pb; a30 = lb; sp0 = sp;
    wlo  = sp - 32'(4 * (la + 1));
    whi  = sp;
    viol = 0;
    exp_q.push_back(expd);
    @(negedge clk);
    setb = 1'b1;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (idle) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic recover();
    @(negedge clk);
    rstb = 1'b1; setb = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b0;
  endtask

  task automatic test_reset();
    rstb = 1'b1; setb = 1'b0;
    pc0 = 8'd0; ra0 = 32'h1234; s00 = 32'd0; a40 = 32'd0;
    a00 = 32'd0; a10 = 32'd0; a20 = 32'd0; a30 = 32'd0; sp0 = 32'h2000;
    repeat (2) @(negedge clk);
    n_assert++; if (idle !== 1'b0) begin n_fail++; $display("FAIL reset_idle got %b want 0", idle); end
    n_assert++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    n_assert++; if (a0 !== 32'd0) begin n_fail++; $display("FAIL reset_a0 got %0d want 0", a0); end
    n_assert++; if (addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr got %h want 0", addr); end
    rstb = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] pb_t [2] = '{32'h1200, 32'h1300};
    int          ex_t [2] = '{5, 2};
    bit ok;
    int e;
    for (int k = 0; k < 2; k++) begin
      start_run(32'h1100, 4, pb_t[k], 5, 32'h2000, ex_t[k]);
      wait_idle(ok);
      e = exp_q.pop_front();
      n_assert++; if (!ok) begin n_fail++; $display("FAIL basic_timeout[%0d] idle=%b want 1", k, idle); recover(); end
      n_assert++; if (a0 !== e) begin n_fail++; $display("FAIL basic_a0[%0d] got %0d want %0d", k, a0, e); end
      n_assert++; if (viol !== 0) begin n_fail++; $display("FAIL basic_bus[%0d] got %0d violations want 0", k, viol); end
      setb = 1'b0;
      @(negedge clk);
      n_assert++; if (idle !== 1'b0) begin n_fail++; $display("FAIL basic_idle_drop[%0d] got %b want 0", k, idle); end
      n_assert++; if (a0 !== e) begin n_fail++; $display("FAIL basic_a0_hold[%0d] got %0d want %0d", k, a0, e); end
    end
  endtask

  task automatic test_edges();
    logic [31:0] pa_t [4] = '{32'h1400, 32'h1400, 32'h1500, 32'h1400};
    int          la_t [4] = '{0, 3, 4, 0};
    logic [31:0] pb_t [4] = '{32'h1400, 32'h1400, 32'h1601, 32'h1400};
    int          lb_t [4] = '{3, 0, 4, 0};
    int          ex_t [4] = '{3, 3, 0, 0};
    bit ok;
    int e;
    for (int k = 0; k < 4; k++) begin
      start_run(pa_t[k], la_t[k], pb_t[k], lb_t[k], 32'h2000, ex_t[k]);
      wait_idle(ok);
      e = exp_q.pop_front();
      n_assert++; if (!ok) begin n_fail++; $display("FAIL edge_timeout[%0d] idle=%b want 1", k, idle); recover(); end
      n_assert++; if (a0 !== e) begin n_fail++; $display("FAIL edge_a0[%0d] got %0d want %0d", k, a0, e); end
      n_assert++; if (viol !== 0) begin n_fail++; $display("FAIL edge_bus[%0d] got %0d violations want 0", k, viol); end
      setb = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_delays();
    int d_t [2] = '{1, 4};
    bit ok;
    int e;
    for (int k = 0; k < 2; k++) begin
      delay = d_t[k];
      start_run(32'h1100, 4, 32'h1300, 5, 32'h2000, 2);
      wait_idle(ok);
      e = exp_q.pop_front();
      n_assert++; if (!ok) begin n_fail++; $display("FAIL delay_timeout[d=%0d] idle=%b want 1", delay, idle); recover(); end
      n_assert++; if (a0 !== e) begin n_fail++; $display("FAIL delay_a0[d=%0d] got %0d want %0d", delay, a0, e); end
      n_assert++; if (viol !== 0) begin n_fail++; $display("FAIL delay_bus[d=%0d] got %0d violations want 0", delay, viol); end
      setb = 1'b0;
      @(negedge clk);
    end
    delay = 1;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int e, la, lb;
    logic [31:0] pa, pb;
    for (int k = 0; k < 6; k++) begin
      la = $urandom_range(0, 7);
      lb = $urandom_range(0, 7);
      pa = 32'h1800 + 32'($urandom_range(0, 3));
      pb = 32'h1900 + 32'($urandom_range(0, 3));
      rand_str(pa, la);
      rand_str(pb, lb);
      delay = $urandom_range(1, 3);
      start_run(pa, la, pb, lb, 32'h3000, lev_model(pa, la, pb, lb));
      wait_idle(ok);
      e = exp_q.pop_front();
      n_assert++; if (!ok) begin n_fail++; $display("FAIL b2b_timeout[%0d] idle=%b want 1", k, idle); recover(); end
      n_assert++; if (a0 !== e) begin n_fail++; $display("FAIL b2b_a0[%0d] la=%0d lb=%0d got %0d want %0d", k, la, lb, a0, e); end
      n_assert++; if (viol !== 0) begin n_fail++; $display("FAIL b2b_bus[%0d] got %0d violations want 0", k, viol); end
      setb = 1'b0;
      @(negedge clk);
    end
    delay = 1;
  endtask

  task automatic test_mid_reset();
    bit ok;
    int e;
    delay = 3;
    start_run(32'h1100, 4, 32'h1200, 5, 32'h2000, 5);
    repeat (40) @(negedge clk);
    void'(exp_q.pop_back());
    rstb = 1'b1;
    setb = 1'b0;
    @(posedge clk);
    #1;
    n_assert++; if (valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid got %b want 0", valid); end
    n_assert++; if (idle !== 1'b0) begin n_fail++; $display("FAIL midreset_idle got %b want 0", idle); end
    @(negedge clk);
    @(negedge clk);
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    start_run(32'h1100, 4, 32'h1200, 5, 32'h2000, 5);
    wait_idle(ok);
    e = exp_q.pop_front();
    n_assert++; if (!ok) begin n_fail++; $display("FAIL midreset_timeout idle=%b want 1", idle); recover(); end
    n_assert++; if (a0 !== e) begin n_fail++; $display("FAIL midreset_a0 got %0d want %0d", a0, e); end
    n_assert++; if (viol !== 0) begin n_fail++; $display("FAIL midreset_bus got %0d violations want 0", viol); end
    setb = 1'b0;
    @(negedge clk);
    delay = 1;
  endtask

  initial begin
    for (int k = 0; k < 16384; k++) mem[k] = 8'h00;
    load_str(32'h1100, "shit");
    load_str(32'h1200, "urmom");
    load_str(32'h1300, "Shit!");
    load_str(32'h1400, "abc");
    load_str(32'h1500, "abcd");
    load_str(32'h1601, "abcd");
    test_reset();
    test_basic();
    test_edges();
    test_delays();
    test_back_to_back();
    test_mid_reset();
    n_assert++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_left got %0d entries want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
